arbitro_pop: RTL and testbench
==============================

ARBITRO_POP -- requirements
Module: arbitro_pop

Interface
REQ-001 The block SHALL have parameter DATA_W, default 6, meaning the word width; bits [DATA_W-1:DATA_W-2] of each word are the destination class.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-003 The block SHALL have port reset_L, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port fifo_empty, input, 4 bits: empty_c of upstream FIFO i on bit i.
REQ-005 The block SHALL have port data_in, input, 4*DATA_W bits: data_out_c of upstream FIFO i on bits [i*DATA_W +: DATA_W].
REQ-006 The block SHALL have port out_almost_full, input, 4 bits: almost_full_c of downstream FIFO j on bit j.
REQ-007 The block SHALL have port pop, output, 4 bits: one-hot-or-zero pop strobe to the upstream FIFOs.
REQ-008 The block SHALL have port push, output, 4 bits: one-hot-or-zero push strobe to the downstream FIFOs.
REQ-009 The block SHALL have port data_out, output, DATA_W bits: the forwarded word, shared by all downstream FIFOs.
REQ-010 The block SHALL have port grant_id, output, 2 bits: index of the last granted upstream FIFO.
REQ-011 The block SHALL have port idle, output, 1 bit: high when the FSM is in IDLE.

Function
REQ-012 All outputs SHALL be registered.
REQ-013 The FSM SHALL have exactly four states: IDLE, POP, CAPT and PUSH.
REQ-014 eligible SHALL equal (fifo_empty != 4'b1111) AND (out_almost_full == 4'b0000), sampled at the current edge.
REQ-015 In IDLE with eligible, the block SHALL select g, the first non-empty index searching upward from rr_ptr modulo 4.
REQ-016 On that grant the block SHALL register pop = 1<<g, grant_id = g and rr_ptr = g+1 (mod 4), and go to POP.
REQ-017 In IDLE without eligible, the block SHALL hold pop = push = 0 and idle = 1.
REQ-018 In POP, the next edge SHALL clear pop and go to CAPT; pop is high for exactly one cycle.
REQ-019 In CAPT, the next edge SHALL register data_out = lane g of data_in and push = 1<<data_out[DATA_W-1:DATA_W-2], and go to PUSH; this accounts for the one-cycle upstream read latency.
REQ-020 In PUSH, the next edge SHALL clear push.
REQ-021 In PUSH, if eligible, the same edge SHALL grant per REQ-015/016 and go to POP; otherwise it SHALL go to IDLE.
REQ-022 Latency SHALL be: pop asserted at edge E0, push asserted at E2, downstream samples at E3; throughput is 1 word per 3 cycles.
REQ-023 pop and push SHALL never be high in the same cycle, and at most one bit of each SHALL be set.
REQ-024 Once pop has issued, push SHALL complete even if out_almost_full rises; downstream almost-full thresholds leave at least one free entry.
REQ-025 The block SHALL never pop a FIFO whose fifo_empty bit was 1 at the grant edge.
REQ-026 rr_ptr wrap-around SHALL be 3 -> 0.
REQ-027 data_out SHALL hold its value between pushes.

Reset
REQ-028 With reset_L = 0 at a posedge, the block SHALL set state = IDLE, pop = 0, push = 0, data_out = 0, grant_id = 0, rr_ptr = 0 and idle = 1.
REQ-029 A reset in POP, CAPT or PUSH SHALL abort the transfer; the popped word is discarded and no push is issued.

Configuration
REQ-030 With macro ARB_FIXED_PRIO_EN defined, the block SHALL grant by fixed priority (index 0 highest) and remove rr_ptr.
REQ-031 Without ARB_FIXED_PRIO_EN, the block SHALL use round-robin per REQ-015/016.

Verification
REQ-032 Reset scenario: reset_L = 0 for 2 cycles, then 1 with fifo_empty = 1111 -> pop = push = 0000, idle = 1, data_out = 0.
REQ-033 Single-transfer scenario: FIFO 2 non-empty, lane 2 = 6'b01_0101 -> pop = 0100 for 1 cycle, push = 0010 two edges later, data_out = 6'h15.
REQ-034 Round-robin scenario: all four FIFOs non-empty, no almost_full -> grant order 0,1,2,3,0 with pops 3 cycles apart.
REQ-035 Backpressure scenario: out_almost_full = 0001 before grant -> no pop until it clears; out_almost_full rising during CAPT -> push still issued, then IDLE.
REQ-036 Mid-transfer reset scenario: reset_L = 0 in CAPT -> no push, state IDLE, rr_ptr = 0.
REQ-037 Fixed-priority scenario: with ARB_FIXED_PRIO_EN, FIFOs 0 and 3 kept non-empty -> FIFO 0 always granted.

Source files
------------

// File: rtl/arbitro_pop.sv
// Moves words from four upstream FIFOs to four downstream FIFOs, routing each word by its top two bits.
// Default grant is round-robin; define ARB_FIXED_PRIO_EN for fixed priority (index 0 highest).
module arbitro_pop #(
    parameter int unsigned DATA_W = 6
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [3:0]            fifo_empty,
    input  logic [4*DATA_W-1:0]   data_in,
    input  logic [3:0]            out_almost_full,
    output logic [3:0]            pop,
    output logic [3:0]            push,
    output logic [DATA_W-1:0]     data_out,
    output logic [1:0]            grant_id,
    output logic                  idle
);

    localparam int unsigned N_PORTS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        CAPT = 2'd2,
        PUSH = 2'd3
    } state_t;

    state_t              state;
    logic                eligible;
    logic [1:0]          grant_nxt;
    logic [DATA_W-1:0]   lane;

`ifndef ARB_FIXED_PRIO_EN
    logic [1:0]          rr_ptr;
`endif

    // Grant selection: first non-empty lane from the search start, plus the lane of the current grant.
    always_comb begin
        eligible  = (fifo_empty != 4'b1111) && (out_almost_full == 4'b0000);
        grant_nxt = 2'd0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            logic [1:0] idx;
`ifdef ARB_FIXED_PRIO_EN
            idx = k[1:0];
`else
            idx = rr_ptr + k[1:0];
`endif
            if (!fifo_empty[idx]) begin
                grant_nxt = idx;
            end
        end
        lane = data_in[int'(grant_id)*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state    <= IDLE;
            pop      <= 4'b0000;
            push     <= 4'b0000;
            data_out <= '0;
            grant_id <= 2'd0;
            idle     <= 1'b1;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr   <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE, PUSH: begin
                    push <= 4'b0000;
                    if (eligible) begin
                        pop      <= 4'b0001 << grant_nxt;
                        grant_id <= grant_nxt;
`ifndef ARB_FIXED_PRIO_EN
                        rr_ptr   <= grant_nxt + 2'd1;
`endif
                        idle     <= 1'b0;
                        state    <= POP;
                    end else begin
                        pop   <= 4'b0000;
                        idle  <= 1'b1;
                        state <= IDLE;
                    end
                end
                POP: begin
                    pop   <= 4'b0000;
                    state <= CAPT;
                end
                CAPT: begin
                    // Upstream data is valid one cycle after the pop strobe.
                    data_out <= lane;
                    push     <= 4'b0001 << lane[DATA_W-1:DATA_W-2];
                    state    <= PUSH;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_pop.sv
// Directed bench for arbitro_pop: reset, single transfer, backpressure, mid-transfer reset, grant order.
module tb_arbitro_pop;

    localparam int unsigned DATA_W = 6;

    logic                clk;
    logic                reset_L;
    logic [3:0]          fifo_empty;
    logic [4*DATA_W-1:0] data_in;
    logic [3:0]          out_almost_full;
    logic [3:0]          pop;
    logic [3:0]          push;
    logic [DATA_W-1:0]   data_out;
    logic [1:0]          grant_id;
    logic                idle;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] lanes [4];
    logic [3:0]        cls_push [4];

    arbitro_pop #(.DATA_W(DATA_W)) dut (
        .clk             (clk),
        .reset_L         (reset_L),
        .fifo_empty      (fifo_empty),
        .data_in         (data_in),
        .out_almost_full (out_almost_full),
        .pop             (pop),
        .push            (push),
        .data_out        (data_out),
        .grant_id        (grant_id),
        .idle            (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        lanes[0] = 6'b00_0001;  cls_push[0] = 4'b0001;
        lanes[1] = 6'b11_0010;  cls_push[1] = 4'b1000;
        lanes[2] = 6'b01_0101;  cls_push[2] = 4'b0010;
        lanes[3] = 6'b10_0111;  cls_push[3] = 4'b0100;
        data_in         = {lanes[3], lanes[2], lanes[1], lanes[0]};
        reset_L         = 1'b0;
        fifo_empty      = 4'b1111;
        out_almost_full = 4'b0000;

        // Reset
        tick();
        tick();
        check("rst_pop", 32'(pop), 32'h0);
        check("rst_push", 32'(push), 32'h0);
        check("rst_idle", 32'(idle), 32'h1);
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_gid", 32'(grant_id), 32'h0);
        reset_L = 1'b1;
        tick();
        check("empty_pop", 32'(pop), 32'h0);
        check("empty_idle", 32'(idle), 32'h1);

        // Single transfer from FIFO 2
        fifo_empty = 4'b1011;
        tick();
        check("single_pop", 32'(pop), 32'h4);
        check("single_gid", 32'(grant_id), 32'h2);
        check("single_idle", 32'(idle), 32'h0);
        fifo_empty = 4'b1111;
        tick();
        check("single_pop_clr", 32'(pop), 32'h0);
        check("single_push_early", 32'(push), 32'h0);
        tick();
        check("single_push", 32'(push), 32'h2);
        check("single_data", 32'(data_out), 32'h15);
        check("single_excl", 32'(pop), 32'h0);
        tick();
        check("single_push_clr", 32'(push), 32'h0);
        check("single_back_idle", 32'(idle), 32'h1);
        tick();
        check("single_data_hold", 32'(data_out), 32'h15);

        // Backpressure before grant, then almost-full rising during CAPT
        fifo_empty      = 4'b1110;
        out_almost_full = 4'b0001;
        tick();
        tick();
        check("bp_no_pop", 32'(pop), 32'h0);
        check("bp_idle", 32'(idle), 32'h1);
        out_almost_full = 4'b0000;
        tick();
        check("bp_pop", 32'(pop), 32'h1);
        check("bp_gid", 32'(grant_id), 32'h0);
        tick();
        out_almost_full = 4'b0001;
        tick();
        check("bp_push", 32'(push), 32'h1);
        check("bp_data", 32'(data_out), 32'(lanes[0]));
        tick();
        check("bp_push_clr", 32'(push), 32'h0);
        check("bp_pop_blocked", 32'(pop), 32'h0);
        check("bp_end_idle", 32'(idle), 32'h1);
        out_almost_full = 4'b0000;
        fifo_empty      = 4'b1111;
        tick();

        // Reset while in CAPT aborts the transfer
        fifo_empty = 4'b1101;
        tick();
        check("mid_pop", 32'(pop), 32'h2);
        tick();
        reset_L = 1'b0;
        tick();
        check("mid_push", 32'(push), 32'h0);
        check("mid_idle", 32'(idle), 32'h1);
        check("mid_gid", 32'(grant_id), 32'h0);
        check("mid_data", 32'(data_out), 32'h0);
        reset_L = 1'b1;
        fifo_empty = 4'b1111;
        tick();
        check("mid_no_push", 32'(push), 32'h0);

`ifdef ARB_FIXED_PRIO_EN
        // Fixed priority: FIFOs 0 and 3 always non-empty, 0 always wins
        fifo_empty = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("fp_pop", 32'(pop), 32'h1);
            check("fp_gid", 32'(grant_id), 32'h0);
            tick();
            tick();
            check("fp_push", 32'(push), 32'(cls_push[0]));
            if (k == 3) fifo_empty = 4'b1111;
        end
        tick();
        check("fp_end_idle", 32'(idle), 32'h1);
`else
        // Round-robin from pointer 0 after reset: 0,1,2,3,0, pops three cycles apart
        fifo_empty = 4'b0000;
        tick();
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % 4;
            check("rr_pop", 32'(pop), 32'(4'b0001 << g));
            check("rr_gid", 32'(grant_id), 32'(g));
            check("rr_push_off", 32'(push), 32'h0);
            tick();
            check("rr_pop_clr", 32'(pop), 32'h0);
            tick();
            check("rr_push", 32'(push), 32'(cls_push[g]));
            check("rr_data", 32'(data_out), 32'(lanes[g]));
            check("rr_excl", 32'(pop), 32'h0);
            if (k == 4) fifo_empty = 4'b1111;
            tick();
        end
        check("rr_end_pop", 32'(pop), 32'h0);
        check("rr_end_idle", 32'(idle), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
